fp_add_arbiter: RTL and testbench

//  Shares one combinational floating_unit (32-bit IEEE-754 add/sub) between NUM_REQ requesters.

---
 rtl/fp_add_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit floating-point
// add/sub unit between NUM_REQ requesters. One operation is in flight at a
// time: IDLE (grant and latch operands), EXEC (capture unit result),
// RESP (hold result until the owning requester accepts it).
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_result,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           fu_a,
    output logic [31:0]           fu_b,
    output logic                  fu_as,
    input  logic [31:0]           fu_result,
    output logic                  busy,
    output logic [CNT_W-1:0]      ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    state_t            state_q,       state_d;
    logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [ID_W-1:0]   owner_q,       owner_d;
    logic [31:0]       fu_a_q,        fu_a_d;
    logic [31:0]       fu_b_q,        fu_b_d;
    logic              fu_as_q,       fu_as_d;
    logic [31:0]       resp_result_q, resp_result_d;
    logic [ID_W-1:0]   resp_id_q,     resp_id_d;
    logic [CNT_W-1:0]  ops_done_q,    ops_done_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W:0]     idx_sum;
    logic [ID_W:0]     rr_inc;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise synthesis infers a latch to hold the old value.
        grant_found = 1'b0;
        grant_id    = '0;
        idx_sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
            if (idx_sum >= NUM_REQ_W) begin
                idx_sum = idx_sum - NUM_REQ_W;
            end
            if (!grant_found && req_valid[idx_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx_sum[ID_W-1:0];
            end
        end
    end

    // Next-state and register-update logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        fu_a_d        = fu_a_q;
        fu_b_d        = fu_b_q;
        fu_as_d       = fu_as_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        ops_done_d    = ops_done_q;
        rr_inc        = {1'b0, grant_id} + (ID_W + 1)'(1);

        case (state_q)
            IDLE: begin
                // A found grant is always a handshake: ready is only raised
                // for a requester that is already valid.
                if (grant_found) begin
                    fu_a_d   = req_a[32*int'(grant_id) +: 32];
                    fu_b_d   = req_b[32*int'(grant_id) +: 32];
                    fu_as_d  = req_op[grant_id];
                    owner_d  = grant_id;
                    rr_ptr_d = (rr_inc == NUM_REQ_W) ? '0 : rr_inc[ID_W-1:0];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = fu_result;
                resp_id_d     = owner_q;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready[owner_q]) begin
                    ops_done_d = ops_done_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs: one-hot ready in IDLE, one-hot valid in RESP.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (!rst_n) begin
            // NOTE: operand and result registers are reset too, so the unit
            // inputs and resp_result come up at a known zero value.
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            fu_a_q        <= '0;
            fu_b_q        <= '0;
            fu_as_q       <= 1'b0;
            resp_result_q <= '0;
            resp_id_q     <= '0;
            ops_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            fu_a_q        <= fu_a_d;
            fu_b_q        <= fu_b_d;
            fu_as_q       <= fu_as_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
            ops_done_q    <= ops_done_d;
        end
    end

    assign fu_a        = fu_a_q;
    assign fu_b        = fu_b_q;
    assign fu_as       = fu_as_q;
    assign resp_result = resp_result_q;
    assign resp_id     = resp_id_q;
    assign busy        = (state_q != IDLE);
    assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter. A behavioural float32 add/sub stands in for
// the floating unit; a transaction-level model (round-robin pointer, op
// count) supplies expected grants, results and counts. A second instance
// with a 3-bit counter exercises counter wrap within a short run.
module tb_fp_add_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_op = '0;
    logic [N-1:0]    resp_ready = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;

    logic [N-1:0]    req_ready, resp_valid;
    logic [31:0]     resp_result, fu_a, fu_b, fu_result;
    logic [1:0]      resp_id;
    logic            fu_as, busy;
    logic [15:0]     ops_done;

    logic [N-1:0]    w_req_ready, w_resp_valid;
    logic [31:0]     w_resp_result, w_fu_a, w_fu_b, w_fu_result;
    logic [1:0]      w_resp_id;
    logic            w_fu_as, w_busy;
    logic [2:0]      w_ops_done;

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    int m_done = 0;

    always #5 clk = ~clk;

    // float32 -> real (finite, normal values only)
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    // real -> float32 (exactly representable values only)
    function automatic logic [31:0] r2f(input real v);
        logic        s;
        real         a;
        int          e;
        logic [22:0] mant;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mant = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), mant};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub);
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return sub ? {~b[31], b[30:0]} : b;
        return r2f(sub ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        int k;
        k = int'($urandom_range(0, 64)) - 32;
        return r2f(real'(k) / 2.0);
    endfunction

    assign fu_result   = fp_addsub(fu_a, fu_b, fu_as);
    assign w_fu_result = fp_addsub(w_fu_a, w_fu_b, w_fu_as);

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_id(resp_id),
        .fu_a(fu_a), .fu_b(fu_b), .fu_as(fu_as), .fu_result(fu_result),
        .busy(busy), .ops_done(ops_done)
    );

    fp_add_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(w_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(w_resp_valid), .resp_ready(resp_ready),
        .resp_result(w_resp_result), .resp_id(w_resp_id),
        .fu_a(w_fu_a), .fu_b(w_fu_b), .fu_as(w_fu_as), .fu_result(w_fu_result),
        .busy(w_busy), .ops_done(w_ops_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        tick();
        tick();
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_done = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, resp_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_handshake: ready=%b valid=%b busy=%b, required all 0",
                     req_ready, resp_valid, busy);
        end
        checks++;
        if ({resp_result, resp_id, ops_done} !== '0) begin
            errors++;
            $display("FAIL reset_resp: result=%h id=%0d ops=%0d, required 0",
                     resp_result, resp_id, ops_done);
        end
        checks++;
        if ({fu_a, fu_b, fu_as} !== '0) begin
            errors++;
            $display("FAIL reset_fu: a=%h b=%h as=%b, required 0", fu_a, fu_b, fu_as);
        end
    endtask

    task automatic test_add_req0();
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_op[0]   = 1'b0;
        req_valid   = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t1_ready: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (resp_valid !== 4'b0000 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL t1_exec: valid=%b busy=%b ready=%b, required 0000/1/0000",
                     resp_valid, busy, req_ready);
        end
        checks++;
        if (fu_a !== 32'h3F800000 || fu_b !== 32'h40000000 || fu_as !== 1'b0) begin
            errors++;
            $display("FAIL t1_fu: a=%h b=%h as=%b, required 3f800000/40000000/0",
                     fu_a, fu_b, fu_as);
        end
        tick();
        checks++;
        if (resp_valid !== 4'b0001 || resp_result !== 32'h40400000 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL t1_resp: valid=%b result=%h id=%0d, required 0001/40400000/0",
                     resp_valid, resp_result, resp_id);
        end
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        m_done = 1;
        m_ptr  = 1;
        checks++;
        if (ops_done !== 16'd1 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL t1_done: ops=%0d busy=%b valid=%b, required 1/0/0000",
                     ops_done, busy, resp_valid);
        end
        checks++;
        if (fu_a !== 32'h3F800000) begin
            errors++;
            $display("FAIL t1_fu_hold: a=%h, required 3f800000", fu_a);
        end
    endtask

    task automatic test_sub_req2();
        req_a[95:64] = 32'h40400000;
        req_b[95:64] = 32'h3F800000;
        req_op[2]    = 1'b1;
        req_valid    = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL t2_ready: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (resp_valid !== 4'b0100 || resp_result !== 32'h40000000 || resp_id !== 2'd2) begin
            errors++;
            $display("FAIL t2_resp: valid=%b result=%h id=%0d, required 0100/40000000/2",
                     resp_valid, resp_result, resp_id);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        m_done = 2;
        m_ptr  = 3;
        req_op[2] = 1'b0;
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'h3FC00000;
            req_b[32*i +: 32] = 32'h40200000;
        end
        req_op    = '0;
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            g = n % N;
            #1;
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                errors++;
                $display("FAIL t3_grant%0d: ready=%b, required %b", n, req_ready, 4'(1 << g));
            end
            tick();
            tick();
            checks++;
            if (resp_id !== 2'(g) || resp_result !== 32'h40800000 || resp_valid !== 4'(1 << g)) begin
                errors++;
                $display("FAIL t3_resp%0d: id=%0d result=%h valid=%b, required %0d/40800000",
                         n, resp_id, resp_result, resp_valid, g);
            end
            resp_ready = '1;
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL t3_noaccept%0d: ready=%b in response cycle, required 0000",
                         n, req_ready);
            end
            tick();
            resp_ready = '0;
        end
        req_valid = '0;
        m_done = 5;
        m_ptr  = 1;
        checks++;
        if (ops_done !== 16'd5) begin
            errors++;
            $display("FAIL t3_count: ops=%0d, required 5", ops_done);
        end
    endtask

    task automatic test_stall();
        req_a[63:32]  = 32'h7F800000;
        req_b[63:32]  = 32'h3F800000;
        req_op[1]     = 1'b0;
        req_a[127:96] = 32'h40800000;
        req_b[127:96] = 32'h3F800000;
        req_op[3]     = 1'b1;
        req_valid     = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL t4_ready: got %b, required 0010", req_ready);
        end
        tick();
        req_valid  = 4'b1000;
        resp_ready = 4'b1101;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (resp_valid !== 4'b0010 || resp_result !== 32'h7F800000 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL t4_hold%0d: valid=%b result=%h ready=%b, required 0010/7f800000/0000",
                         i, resp_valid, resp_result, req_ready);
            end
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        checks++;
        if (req_ready !== 4'b1000 || ops_done !== 16'd6) begin
            errors++;
            $display("FAIL t4_next: ready=%b ops=%0d, required 1000/6", req_ready, ops_done);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (resp_id !== 2'd3 || resp_result !== 32'h40400000 || resp_valid !== 4'b1000) begin
            errors++;
            $display("FAIL t4_req3: id=%0d result=%h valid=%b, required 3/40400000/1000",
                     resp_id, resp_result, resp_valid);
        end
        resp_ready = 4'b1000;
        tick();
        resp_ready = '0;
        m_done = 7;
        m_ptr  = 0;
    endtask

    task automatic test_reset_exec();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL t5_ready: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, resp_result, resp_id, ops_done, fu_a, fu_b, fu_as} !== '0) begin
            errors++;
            $display("FAIL t5_async: busy=%b valid=%b ops=%0d fu_a=%h, required all 0",
                     busy, resp_valid, ops_done, fu_a);
        end
        tick();
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL t5_quiet%0d: valid=%b busy=%b, required 0000/0", i, resp_valid, busy);
            end
        end
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t5_ptr: ready=%b, required 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic [31:0]  exp_res;
        int           g;
        int           found;
        int           d;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = rnd_fp();
                req_b[32*i +: 32] = rnd_fp();
            end
            req_op    = 4'($urandom);
            mask      = 4'($urandom_range(1, 15));
            req_valid = mask;
            g     = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (found == 0 && mask[(m_ptr + k) % N]) begin
                    g     = (m_ptr + k) % N;
                    found = 1;
                end
            end
            exp_res = fp_addsub(req_a[32*g +: 32], req_b[32*g +: 32], req_op[g]);
            #1;
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                errors++;
                $display("FAIL rnd%0d_grant: ready=%b, required %b", n, req_ready, 4'(1 << g));
            end
            tick();
            req_valid = 4'($urandom);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_exec: ready=%b busy=%b, required 0000/1", n, req_ready, busy);
            end
            tick();
            d = int'($urandom_range(0, 3));
            for (int c = 0; c <= d; c++) begin
                resp_ready = 4'($urandom) & ~4'(1 << g);
                if (c == d) resp_ready = resp_ready | 4'(1 << g);
                #1;
                checks++;
                if (resp_valid !== 4'(1 << g) || resp_id !== 2'(g) || resp_result !== exp_res
                    || req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL rnd%0d_resp: valid=%b id=%0d result=%h ready=%b, required %b/%0d/%h/0000",
                             n, resp_valid, resp_id, resp_result, req_ready, 4'(1 << g), g, exp_res);
                end
                tick();
            end
            resp_ready = '0;
            req_valid  = '0;
            m_done++;
            m_ptr = (g + 1) % N;
            #1;
            checks++;
            if (ops_done !== 16'(m_done) || w_ops_done !== 3'(m_done)) begin
                errors++;
                $display("FAIL rnd%0d_count: ops=%0d small=%0d, required %0d/%0d",
                         n, ops_done, w_ops_done, 16'(m_done), 3'(m_done));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_req0();
        test_sub_req2();
        test_round_robin();
        test_stall();
        test_reset_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
